// File: rtl/color_mode_select_pkg.sv
// -----------------------------------------------------------------------------
// color_mode_select_pkg
//   Shared definitions for the front-panel colour chooser.
//   - Palette codes. The RGB PWM/blink driver uses the same numbering:
//     0 = maroon .. 12 = silver, and 13 = off.
//   - Default palette size.
//   - Chooser FSM state encoding.
//   - Helpers that step the browse index with wrap-around.
// -----------------------------------------------------------------------------
package color_mode_select_pkg;

    localparam logic [3:0] C_MAROON = 4'd0;
    localparam logic [3:0] C_SILVER = 4'd12;
    localparam logic [3:0] C_OFF    = 4'd13;

    localparam int NUM_COLORS_DEF = 13;

    typedef enum logic [1:0] {
        S_DIS     = 2'd0,
        S_BROWSE  = 2'd1,
        S_CONFIRM = 2'd2
    } state_t;

    // Forward step. Any index at or beyond the last code wraps to 0,
    // so a code outside the palette can never be produced.
    function automatic logic [3:0] idx_next(input logic [3:0] idx, input logic [3:0] last);
        return (idx >= last) ? 4'd0 : idx + 4'd1;
    endfunction

    // Backward step. 0 wraps to the last palette code.
    function automatic logic [3:0] idx_prev(input logic [3:0] idx, input logic [3:0] last);
        return (idx == 4'd0) ? last : idx - 4'd1;
    endfunction

endpackage

// File: rtl/color_mode_select_if.sv
// -----------------------------------------------------------------------------
// color_mode_select_if
//   Front-panel bundle between the buttons/driver side and the colour chooser.
//
//   Signals:
//     en            - block enable (shared with the RGB driver)
//     btn_next_raw  - raw "next colour" button
//     btn_prev_raw  - raw "previous colour" button
//     btn_sel_raw   - raw "confirm" button
//     cmode_colorch - browsed palette code, to the driver
//     cmode_btn0    - confirm strobe, to the driver
//     active_color  - last confirmed code, for the status display
//
//   Modports:
//     master - panel/driver side
//     slave  - the chooser
// -----------------------------------------------------------------------------
interface color_mode_select_if;
    logic       en;
    logic       btn_next_raw;
    logic       btn_prev_raw;
    logic       btn_sel_raw;
    logic [3:0] cmode_colorch;
    logic       cmode_btn0;
    logic [3:0] active_color;

    modport master (
        output en, btn_next_raw, btn_prev_raw, btn_sel_raw,
        input  cmode_colorch, cmode_btn0, active_color
    );

    modport slave (
        input  en, btn_next_raw, btn_prev_raw, btn_sel_raw,
        output cmode_colorch, cmode_btn0, active_color
    );
endinterface

// File: rtl/color_mode_select_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Cleans up one raw push-button.
//   Signal path: 2-FF synchroniser -> stability counter -> debounced level.
//   A press also produces a one-cycle rise_pulse. A release produces no pulse.
//
//   Ports:
//     clk        - system clock
//     nrst       - asynchronous active-low reset
//     raw        - asynchronous button input
//     level      - debounced button level
//     rise_pulse - one-cycle pulse, high in the cycle after level rises
//
//   Latency: a press stable from just after edge 0 makes rise_pulse and level
//   rise after edge 2 + DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            // ---- synchroniser stages ----
            sync_p0    <= raw;
            sync_p1    <= sync_p0;
            rise_pulse <= 1'b0;
            // ---- stability counter ----
            // cnt only advances while the synced input disagrees with level.
            // Any bounce back to the current level restarts the count.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                level      <= sync_p1;
                rise_pulse <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_mode_select.sv
// -----------------------------------------------------------------------------
// color_mode_select
//   Front-panel colour chooser that feeds the RGB PWM/blink driver.
//   - Debounces the next/prev/sel buttons.
//   - Browses the palette index with wrap-around.
//   - A confirm press issues a CONFIRM_CYCLES-wide strobe on cmode_btn0.
//     The chosen code is held on cmode_colorch during the strobe.
//
//   Ports:
//     clk  - system clock
//     nrst - asynchronous active-low reset
//     bus  - color_mode_select_if.slave
//            inputs:  en, btn_next_raw, btn_prev_raw, btn_sel_raw
//            outputs: cmode_colorch, cmode_btn0, active_color (all registered)
// -----------------------------------------------------------------------------
module color_mode_select
    import color_mode_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CONFIRM_CYCLES  = 1,
    parameter int NUM_COLORS      = NUM_COLORS_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    color_mode_select_if.slave    bus
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_COLORS - 1);
    localparam int SC_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(CONFIRM_CYCLES - 1);

    logic next_pulse;
    logic prev_pulse;
    logic sel_pulse;
    // Only the press edges drive the FSM; the debounced levels are not needed.
    logic [2:0] level_unused;

    state_t          state_q,   state_d;
    logic [3:0]      colorch_q, colorch_d;
    logic            btn0_q,    btn0_d;
    logic [3:0]      active_q,  active_d;
    logic [SC_W-1:0] scnt_q,    scnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk        (clk),
        .nrst       (nrst),
        .raw        (bus.btn_next_raw),
        .level      (level_unused[0]),
        .rise_pulse (next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk        (clk),
        .nrst       (nrst),
        .raw        (bus.btn_prev_raw),
        .level      (level_unused[1]),
        .rise_pulse (prev_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk        (clk),
        .nrst       (nrst),
        .raw        (bus.btn_sel_raw),
        .level      (level_unused[2]),
        .rise_pulse (sel_pulse)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_DIS;
            colorch_q <= C_MAROON;
            btn0_q    <= 1'b0;
            active_q  <= C_MAROON;
            scnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            colorch_q <= colorch_d;
            btn0_q    <= btn0_d;
            active_q  <= active_d;
            scnt_q    <= scnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        colorch_d = colorch_q;
        btn0_d    = btn0_q;
        active_d  = active_q;
        scnt_d    = scnt_q;

        // Dropping en wins from any state and aborts a strobe at once.
        // active_color is kept for the status display.
        if (!bus.en) begin
            state_d   = S_DIS;
            colorch_d = C_MAROON;
            btn0_d    = 1'b0;
            scnt_d    = '0;
        end else begin
            case (state_q)
                S_DIS: begin
                    // The driver also restarts at maroon when enabled.
                    state_d   = S_BROWSE;
                    colorch_d = C_MAROON;
                    btn0_d    = 1'b0;
                    scnt_d    = '0;
                end
                S_BROWSE: begin
                    // sel outranks next/prev in the same cycle.
                    // next and prev together cancel out.
                    if (sel_pulse) begin
                        state_d  = S_CONFIRM;
                        btn0_d   = 1'b1;
                        active_d = colorch_q;
                        scnt_d   = '0;
                    end else if (next_pulse && !prev_pulse) begin
                        colorch_d = idx_next(colorch_q, LAST_IDX);
                    end else if (prev_pulse && !next_pulse) begin
                        colorch_d = idx_prev(colorch_q, LAST_IDX);
                    end
                end
                S_CONFIRM: begin
                    // Button pulses arriving here are dropped, not queued.
                    if (scnt_q == SC_LAST) begin
                        state_d = S_BROWSE;
                        btn0_d  = 1'b0;
                        scnt_d  = '0;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = S_DIS;
                    colorch_d = C_MAROON;
                    btn0_d    = 1'b0;
                    scnt_d    = '0;
                end
            endcase
        end
    end

    assign bus.cmode_colorch = colorch_q;
    assign bus.cmode_btn0    = btn0_q;
    assign bus.active_color  = active_q;

endmodule
